// File: rtl/rf_rmw_ctrl_pkg.sv
// Shared types for the register-file read-modify-write controller: op codes, FSM states, default sizes.
package rf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AW    = 3;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_AND  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/rf_rmw_ctrl_if.sv
// Request handshake plus register-file read/write port of the RMW controller.
interface rf_rmw_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [AW-1:0]    req_src;
  logic [AW-1:0]    req_dst;
  logic [WIDTH-1:0] req_operand;
  logic [AW-1:0]    rAddr;
  logic [WIDTH-1:0] rData;
  logic             we;
  logic [AW-1:0]    wAddr;
  logic [WIDTH-1:0] wData;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  // Requester and register file side
  modport master (
    output req_valid, req_op, req_src, req_dst, req_operand, rData,
    input  req_ready, rAddr, we, wAddr, wData, done, result, carry, zero
  );

  // Controller side
  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_operand, rData,
    output req_ready, rAddr, we, wAddr, wData, done, result, carry, zero
  );
endinterface

// File: rtl/rf_rmw_ctrl_alu.sv
// Combinational ALU for the RMW controller; c is carry (ADD) or borrow (SUB).
// With RF_RMW_SAT_EN defined, ADD clamps to all-ones on carry and SUB clamps to zero on borrow.
module rf_rmw_alu
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] r,
  output logic             c
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is set exactly when a < b
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  {c, r} = w_sum;
      OP_SUB:  {c, r} = w_diff;
      OP_AND:  r = a & b;
      OP_PASS: r = b;
      default: r = '0;
    endcase
`ifdef RF_RMW_SAT_EN
    if (c) begin
      r = (op == OP_ADD) ? '1 : '0;
    end
`endif
  end

endmodule

// File: rtl/rf_rmw_ctrl.sv
// Read-modify-write sequencer upstream of the 8x32 register file: IDLE->READ->EXEC->WRITE, one op per 4 cycles.
// Saturating ADD/SUB selected by RF_RMW_SAT_EN (implemented in rf_rmw_alu).
module rf_rmw_ctrl
  import rf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic         clk,
  input  logic         reset,
  rf_rmw_ctrl_if.slave bus
);
  state_e           r_state;
  logic             r_ready;
  logic             r_we;
  op_e              r_op;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_c;

  rf_rmw_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (r_a),
    .b  (r_operand),
    .op (r_op),
    .r  (w_alu_r),
    .c  (w_alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_we      <= 1'b0;
      r_op      <= OP_ADD;
      r_src     <= '0;
      r_dst     <= '0;
      r_operand <= '0;
      r_a       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_op      <= op_e'(bus.req_op);
            r_src     <= bus.req_src;
            r_dst     <= bus.req_dst;
            r_operand <= bus.req_operand;
            r_ready   <= 1'b0;
            r_state   <= READ;
          end
        end
        READ: begin
          r_a     <= bus.rData;
          r_state <= EXEC;
        end
        EXEC: begin
          // Flags and result move together so they are valid throughout the write cycle
          r_res   <= w_alu_r;
          r_carry <= w_alu_c;
          r_zero  <= (w_alu_r == '0);
          r_we    <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          r_we    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // r_res only changes on the edge into WRITE, so it doubles as the held result
  assign bus.req_ready = r_ready;
  assign bus.rAddr     = r_src;
  assign bus.we        = r_we;
  assign bus.done      = r_we;
  assign bus.wAddr     = r_dst;
  assign bus.wData     = r_res;
  assign bus.result    = r_res;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;

endmodule

// File: doc/rf_rmw_ctrl.md
# rf_rmw_ctrl

Read-modify-write sequencer for the 8 x 32-bit register file, sitting directly upstream of it. It accepts one operation request, reads the source register, and combines that value with a request operand in a small ALU. It then writes the result into the destination register through the file's write port (`we`/`wAddr`/`wData`). The register file's read port is combinational: `rData` follows `rAddr` in the same cycle. Its write port commits on the rising `clk` edge while `we`=1.

## Interface
Parameters:
- `WIDTH`, 32, data width; matches the register-file word.
- `AW`, 3, register address width (8 registers).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request (high only in IDLE).
- `req_op`  in  2  operation: 0 ADD, 1 SUB (src - operand), 2 AND, 3 PASS (operand only).
- `req_src`  in  AW  source register address.
- `req_dst`  in  AW  destination register address.
- `req_operand`  in  WIDTH  second operand.
- `rAddr`  out  AW  register-file read address.
- `rData`  in  WIDTH  register-file read data.
- `we`  out  1  register-file write enable.
- `wAddr`  out  AW  register-file write address.
- `wData`  out  WIDTH  register-file write data.
- `done`  out  1  one-cycle pulse; coincides with the write cycle.
- `result`  out  WIDTH  last written value; held until the next write.
- `carry`  out  1  carry-out (ADD) or borrow (SUB) of the last op; 0 for AND/PASS.
- `zero`  out  1  `result`==0.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_op`, `req_src`, `req_dst` and `req_operand`, then go to READ.
- **READ**
  - `rAddr` = latched src.
  - Capture `rData` into the operand-A register at the clock edge, then go to EXEC.
- **EXEC**
  - Compute `{c, r}` = the WIDTH+1-bit result of the op on operand A and the latched operand.
    - ADD: A + op.
    - SUB: A - op; borrow = (A < op).
  - Register `r` and `c`, then go to WRITE.
- **WRITE**
  - `we`=1, `wAddr` = latched dst, `wData` = registered result, `done`=1.
  - Update `result`, `carry` and `zero` at this edge, then go to IDLE.
- `rAddr` drives the latched src in every state other than READ; it is 0 after reset.
- `req_ready`=0 in READ, EXEC and WRITE. New requests wait in the requester; none are dropped.
- src == dst is legal. The read completes before the write, so the op uses the old value.
- Arithmetic is unsigned modulo 2^WIDTH, unless the saturation feature is enabled (see Configuration).
- Reset (asynchronous, any time):
  - State returns to IDLE.
  - `we`, `done`, `carry` and `result` go to 0; `zero`=1; `rAddr` and `wAddr` go to 0.
  - A request in progress is abandoned and its register write does not happen.

## Timing
- Cycle 0: handshake (`req_valid`&`req_ready`) in IDLE.
- Cycle 1: READ. Cycle 2: EXEC. Cycle 3: WRITE (`we`=`done`=1).
- The register file holds the new value from cycle 4.
- Throughput is one operation per 4 cycles. The next handshake is possible in cycle 4.
- `req_ready` is a registered output, taken directly from the state.
- `we` and `done` are high for exactly one cycle per operation.

## Configuration
- Macro: `RF_RMW_SAT_EN`.
- When defined, ADD and SUB saturate:
  - ADD with carry writes all-ones.
  - SUB with borrow writes 0.
  - `carry` still reports the overflow or borrow.
- When undefined, ADD and SUB wrap modulo 2^WIDTH.
- AND and PASS behave the same either way.

## Structure
- Shared package `rf_pkg`: op encodings (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_PASS`), FSM state enum, default `WIDTH`/`AW`.
- One sub-module, `rf_rmw_alu`: combinational; inputs a, b, op; outputs r, c; holds the saturation logic under `RF_RMW_SAT_EN`.
- The FSM and handshake stay in the top level.

## Test plan
- After reset, ADD src=1, dst=2, operand=5, with reg1=10 → write cycle 3: `wAddr`=2, `wData`=15, `carry`=0, `zero`=0; `req_ready`=1 again in cycle 4.
- ADD, reg0=0xFFFFFFFF, operand=1 → wrap build: `wData`=0, `carry`=1, `zero`=1; `RF_RMW_SAT_EN` build: `wData`=0xFFFFFFFF, `carry`=1.
- SUB src=dst=3, reg3=4, operand=9 → wrap: `wData`=0xFFFFFFFB with borrow=1; saturating: 0. Reg3 is read before it is written.
- `req_valid` held high continuously, issuing 3 requests → exactly 3 `we` pulses in cycles 3, 7 and 11; `req_ready` is low between handshakes.
- `reset` asserted during EXEC → `we` never pulses, the destination register is unchanged, outputs take their reset values immediately, and the controller accepts a request in the first cycle after release.
- AND with operand 0x0000FFFF on 0x12345678 → `wData`=0x00005678; PASS with operand 0xA5A5A5A5 → `wData`=0xA5A5A5A5; `carry`=0 for both.
